// File: rtl/toy_fetch_mem_responder_if.sv
// Fetch request/ack handshake bundle between a fetch unit (master) and the
// line responder (slave).
interface toy_fetch_mem_responder_if #(
  parameter int ADDR_WIDTH       = 32,
  parameter int FETCH_DATA_WIDTH = 256,
  parameter int ID_WIDTH         = 48
);
  logic                        fetch_mem_req_vld;
  logic                        fetch_mem_req_rdy;
  logic [ADDR_WIDTH-1:0]       fetch_mem_req_addr;
  logic [ID_WIDTH-1:0]         fetch_mem_req_entry_id;
  logic                        fetch_mem_ack_vld;
  logic                        fetch_mem_ack_rdy;
  logic [FETCH_DATA_WIDTH-1:0] fetch_mem_ack_data;
  logic [ID_WIDTH-1:0]         fetch_mem_ack_entry_id;

  modport master (
    output fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id,
    output fetch_mem_ack_rdy,
    input  fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data,
    input  fetch_mem_ack_entry_id
  );

  modport slave (
    input  fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id,
    input  fetch_mem_ack_rdy,
    output fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data,
    output fetch_mem_ack_entry_id
  );
endinterface

// File: rtl/toy_fetch_mem_responder.sv
// Fetch line responder: queues up to two requests and assembles each line from BEATS bus reads.
// Define TOY_FETCH_RESP_CRIT_FIRST_EN to issue the beat holding req_addr first (wrapping in the line).
module toy_fetch_mem_responder #(
  parameter int ADDR_WIDTH       = 32,
  parameter int FETCH_DATA_WIDTH = 256,
  parameter int BUS_DATA_WIDTH   = 64,
  parameter int ID_WIDTH         = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  toy_fetch_mem_responder_if.slave  fetch_if,
  output logic                      mem_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [BUS_DATA_WIDTH-1:0] mem_rd_data
);

  localparam int BEATS      = FETCH_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int BUS_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int LINE_BYTES = FETCH_DATA_WIDTH / 8;
  localparam int BUS_LSB    = $clog2(BUS_BYTES);
  localparam int LINE_LSB   = $clog2(LINE_BYTES);
  localparam int LANE_W     = $clog2(BEATS);

  typedef logic [LANE_W-1:0] lane_t;
  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic [ID_WIDTH-1:0]   fifo_id_q   [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  state_t                                 state_q;
  lane_t                                  beat_q;
  logic                                   cap_vld_q;
  lane_t                                  cap_lane_q;
  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   line_q;
  logic                                   ack_vld_q;
  logic [ID_WIDTH-1:0]                    ack_id_q;

  logic [ADDR_WIDTH-1:0] head_addr, line_base, beat_addr;
  lane_t                 beat_lane;

  // Ready looks only at the registered count, so a same-cycle pop never opens a slot early.
  assign fetch_if.fetch_mem_req_rdy = ~rst & (count_q != 2'd2);
  assign push    = fetch_if.fetch_mem_req_vld & fetch_if.fetch_mem_req_rdy;
  assign pop     = ack_vld_q & fetch_if.fetch_mem_ack_rdy;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign line_base = head_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);

`ifdef TOY_FETCH_RESP_CRIT_FIRST_EN
  // Lane arithmetic is LANE_W wide, so the critical-first order wraps inside the line.
  assign beat_lane = head_addr[LINE_LSB-1:BUS_LSB] + beat_q;
`else
  assign beat_lane = beat_q;
`endif

  assign beat_addr = line_base | (ADDR_WIDTH'(beat_lane) << BUS_LSB);
  assign mem_en    = (state_q == READ);
  assign mem_addr  = mem_en ? beat_addr : '0;

  assign fetch_if.fetch_mem_ack_vld      = ack_vld_q;
  assign fetch_if.fetch_mem_ack_data     = line_q;
  assign fetch_if.fetch_mem_ack_entry_id = ack_id_q;

  // NOTE: pure storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= fetch_if.fetch_mem_req_addr;
      fifo_id_q[wr_ptr_q]   <= fetch_if.fetch_mem_req_entry_id;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      state_q    <= IDLE;
      beat_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= '0;
      line_q     <= '0;
      ack_vld_q  <= 1'b0;
      ack_id_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;

      // Read data returns one cycle after issue; remember which lane it belongs to.
      cap_vld_q  <= mem_en;
      cap_lane_q <= beat_lane;
      if (cap_vld_q) line_q[cap_lane_q] <= mem_rd_data;

      case (state_q)
        IDLE: begin
          if (count_q != 2'd0) begin
            state_q <= READ;
            beat_q  <= '0;
          end
        end
        READ: begin
          if (beat_q == lane_t'(BEATS - 1)) begin
            state_q <= WAIT;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        WAIT: begin
          state_q   <= RESP;
          ack_vld_q <= 1'b1;
          ack_id_q  <= fifo_id_q[rd_ptr_q];
        end
        RESP: begin
          if (fetch_if.fetch_mem_ack_rdy) begin
            ack_vld_q <= 1'b0;
            state_q   <= (count_d != 2'd0) ? READ : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_fetch_mem_responder.sv
// Self-checking bench for toy_fetch_mem_responder: directed scenarios plus a
// randomized run compared against a line-level reference model.
module tb_toy_fetch_mem_responder;
  localparam int AW = 32, FW = 256, BW = 64, IW = 48, BEATS = 4;

  typedef struct {
    logic [IW-1:0] id;
    logic [FW-1:0] data;
    int            cyc;
  } ack_rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rd_data = '0;
  logic [31:0]   salt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int overlap_cnt = 0;
  logic ack_vld_prev = 1'b0;

  logic [AW-1:0] obs_addr[$];
  ack_rec_t      ack_q[$];
  int            rise_q[$];

  toy_fetch_mem_responder_if #(.ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(FW), .ID_WIDTH(IW)) bus ();

  toy_fetch_mem_responder #(
    .ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(FW), .BUS_DATA_WIDTH(BW), .ID_WIDTH(IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_if    (bus),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: word(a) = {salt, a}; junk whenever no read was issued.
  always @(posedge clk)
    mem_rd_data <= mem_en ? {salt, mem_addr} : {$urandom, $urandom};

  // Observer only records events; the test tasks judge them.
  always @(negedge clk) begin
    if (mem_en) obs_addr.push_back(mem_addr);
    if (mem_en && bus.fetch_mem_ack_vld) overlap_cnt++;
    if (bus.fetch_mem_ack_vld && !ack_vld_prev) rise_q.push_back(cyc);
    if (bus.fetch_mem_ack_vld && bus.fetch_mem_ack_rdy)
      ack_q.push_back('{bus.fetch_mem_ack_entry_id, bus.fetch_mem_ack_data, cyc});
    ack_vld_prev = bus.fetch_mem_ack_vld;
  end

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_beat_addr(input logic [AW-1:0] a, input int i);
    int lane;
`ifdef TOY_FETCH_RESP_CRIT_FIRST_EN
    lane = (int'((a % 32) / 8) + i) % BEATS;
`else
    lane = i;
`endif
    return (a & ~32'h1F) + 32'(lane * 8);
  endfunction

  function automatic logic [FW-1:0] exp_line(input logic [AW-1:0] a, input logic [31:0] s);
    logic [FW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = {s, (a & ~32'h1F) + 32'(k * 8)};
    return l;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id, output int acc);
    bit got = 0;
    acc = -1;
    bus.fetch_mem_req_addr     = a;
    bus.fetch_mem_req_entry_id = id;
    bus.fetch_mem_req_vld      = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.fetch_mem_req_rdy) begin
        got = 1;
        acc = cyc;
      end
      @(posedge clk); #1;
    end
    bus.fetch_mem_req_vld = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_accept: addr %h not accepted within 300 cycles", a);
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int i = 0;
    while (ack_q.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (ack_q.size() < n) begin
      checks++; errors++;
      $display("FAIL ack_wait: have %0d acks, need %0d", ack_q.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.fetch_mem_req_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy: got %b want 0", bus.fetch_mem_req_rdy); end
    if (bus.fetch_mem_ack_vld !== 1'b0) begin errors++; $display("FAIL rst_ack_vld: got %b want 0", bus.fetch_mem_ack_vld); end
    if (bus.fetch_mem_ack_data !== '0) begin errors++; $display("FAIL rst_ack_data: got %h want 0", bus.fetch_mem_ack_data); end
    if (bus.fetch_mem_ack_entry_id !== '0) begin errors++; $display("FAIL rst_ack_id: got %h want 0", bus.fetch_mem_ack_entry_id); end
    if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fetch_mem_req_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_rdy: got %b want 1", bus.fetch_mem_req_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ab = ack_q.size(), rb = rise_q.size(), ob = obs_addr.size(), acc;
    logic [AW-1:0] a = 32'h0000_1008;
    salt = 32'h0;
    bus.fetch_mem_ack_rdy = 1'b1;
    send(a, 48'h5, acc);
    wait_acks(ab + 1, 40);
    checks++;
    if (obs_addr.size() != ob + BEATS) begin errors++; $display("FAIL basic_beats: got %0d reads want %0d", obs_addr.size() - ob, BEATS); end
    for (int i = 0; i < BEATS && ob + i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[ob+i] !== model_beat_addr(a, i)) begin
        errors++; $display("FAIL basic_addr%0d: got %h want %h", i, obs_addr[ob+i], model_beat_addr(a, i));
      end
    end
    if (rise_q.size() > rb) begin
      checks++;
      if (rise_q[rb] != acc + 7) begin errors++; $display("FAIL basic_latency: ack at T+%0d want T+7", rise_q[rb] - acc); end
    end
    if (ack_q.size() > ab) begin
      checks += 2;
      if (ack_q[ab].data !== exp_line(a, salt)) begin errors++; $display("FAIL basic_data: got %h want %h", ack_q[ab].data, exp_line(a, salt)); end
      if (ack_q[ab].id !== 48'h5) begin errors++; $display("FAIL basic_id: got %h want 5", ack_q[ab].id); end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int ab = ack_q.size(), rb = rise_q.size(), ob = obs_addr.size(), acc, i = 0;
    logic [AW-1:0] a1 = $urandom, a2 = $urandom;
    logic [IW-1:0] id1 = {16'($urandom), 32'($urandom)}, id2 = {16'($urandom), 32'($urandom)};
    salt = $urandom;
    bus.fetch_mem_ack_rdy = 1'b0;
    send(a1, id1, acc);
    while (rise_q.size() == rb && i < 40) begin @(posedge clk); #1; i++; end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks += 4;
      if (bus.fetch_mem_ack_vld !== 1'b1) begin errors++; $display("FAIL hold_vld c%0d: got %b want 1", c, bus.fetch_mem_ack_vld); end
      if (bus.fetch_mem_ack_data !== exp_line(a1, salt)) begin errors++; $display("FAIL hold_data c%0d: got %h want %h", c, bus.fetch_mem_ack_data, exp_line(a1, salt)); end
      if (bus.fetch_mem_ack_entry_id !== id1) begin errors++; $display("FAIL hold_id c%0d: got %h want %h", c, bus.fetch_mem_ack_entry_id, id1); end
      if (mem_en !== 1'b0) begin errors++; $display("FAIL hold_mem_en c%0d: got %b want 0", c, mem_en); end
      if (c == 3) begin
        checks++;
        if (bus.fetch_mem_req_rdy !== 1'b1) begin errors++; $display("FAIL hold_req_rdy: got %b want 1", bus.fetch_mem_req_rdy); end
      end
      @(posedge clk); #1;
      if (c == 2) begin
        bus.fetch_mem_req_addr = a2; bus.fetch_mem_req_entry_id = id2; bus.fetch_mem_req_vld = 1'b1;
      end
      if (c == 3) bus.fetch_mem_req_vld = 1'b0;
    end
    checks++;
    if (ack_q.size() != ab) begin errors++; $display("FAIL hold_no_pop: got %0d pops want 0", ack_q.size() - ab); end
    bus.fetch_mem_ack_rdy = 1'b1;
    wait_acks(ab + 2, 60);
    if (ack_q.size() >= ab + 2) begin
      checks += 4;
      if (ack_q[ab].id !== id1) begin errors++; $display("FAIL bp_id0: got %h want %h", ack_q[ab].id, id1); end
      if (ack_q[ab].data !== exp_line(a1, salt)) begin errors++; $display("FAIL bp_data0: got %h want %h", ack_q[ab].data, exp_line(a1, salt)); end
      if (ack_q[ab+1].id !== id2) begin errors++; $display("FAIL bp_id1: got %h want %h", ack_q[ab+1].id, id2); end
      if (ack_q[ab+1].data !== exp_line(a2, salt)) begin errors++; $display("FAIL bp_data1: got %h want %h", ack_q[ab+1].data, exp_line(a2, salt)); end
    end
    checks++;
    if (obs_addr.size() != ob + 2 * BEATS) begin errors++; $display("FAIL bp_reads: got %0d want %0d", obs_addr.size() - ob, 2 * BEATS); end
  endtask

  task automatic test_back_to_back();
    int ab = ack_q.size(), acc1, acc2, acc3;
    logic [AW-1:0] a[3];
    salt = $urandom;
    for (int k = 0; k < 3; k++) a[k] = $urandom;
    bus.fetch_mem_ack_rdy = 1'b1;
    send(a[0], 48'h1, acc1);
    send(a[1], 48'h2, acc2);
    checks++;
    if (acc2 != acc1 + 1) begin errors++; $display("FAIL b2b_second_accept: got T+%0d want T+1", acc2 - acc1); end
    bus.fetch_mem_req_vld = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fetch_mem_req_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full_rdy: got %b want 0", bus.fetch_mem_req_rdy); end
    @(posedge clk); #1;
    send(a[2], 48'h3, acc3);
    wait_acks(ab + 3, 80);
    if (ack_q.size() >= ab + 3) begin
      checks++;
      if (acc3 <= ack_q[ab].cyc) begin errors++; $display("FAIL b2b_third_accept: accepted cycle %0d, first ack cycle %0d", acc3, ack_q[ab].cyc); end
      for (int k = 0; k < 3; k++) begin
        checks += 2;
        if (ack_q[ab+k].id !== 48'(k + 1)) begin errors++; $display("FAIL b2b_order%0d: got %h want %0d", k, ack_q[ab+k].id, k + 1); end
        if (ack_q[ab+k].data !== exp_line(a[k], salt)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, ack_q[ab+k].data, exp_line(a[k], salt)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ab = ack_q.size(), rb = rise_q.size(), ob = obs_addr.size(), acc, i = 0;
    logic [AW-1:0] a2 = $urandom;
    salt = $urandom;
    bus.fetch_mem_ack_rdy = 1'b1;
    send($urandom, 48'hDEAD, acc);
    while (obs_addr.size() < ob + 2 && i < 30) begin @(posedge clk); #1; i++; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 6;
    if (bus.fetch_mem_req_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_req_rdy: got %b want 0", bus.fetch_mem_req_rdy); end
    if (bus.fetch_mem_ack_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_ack_vld: got %b want 0", bus.fetch_mem_ack_vld); end
    if (bus.fetch_mem_ack_data !== '0) begin errors++; $display("FAIL mid_rst_ack_data: got %h want 0", bus.fetch_mem_ack_data); end
    if (bus.fetch_mem_ack_entry_id !== '0) begin errors++; $display("FAIL mid_rst_ack_id: got %h want 0", bus.fetch_mem_ack_entry_id); end
    if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_en: got %b want 0", mem_en); end
    if (mem_addr !== '0) begin errors++; $display("FAIL mid_rst_mem_addr: got %h want 0", mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fetch_mem_req_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_release_rdy: got %b want 1", bus.fetch_mem_req_rdy); end
    repeat (15) @(posedge clk); #1;
    checks++;
    if (ack_q.size() != ab || rise_q.size() != rb) begin errors++; $display("FAIL mid_rst_no_ack: got %0d acks want 0", rise_q.size() - rb); end
    send(a2, 48'h77, acc);
    wait_acks(ab + 1, 40);
    if (ack_q.size() > ab && rise_q.size() > rb) begin
      checks += 3;
      if (rise_q[rb] != acc + 7) begin errors++; $display("FAIL mid_rst_latency: ack at T+%0d want T+7", rise_q[rb] - acc); end
      if (ack_q[ab].data !== exp_line(a2, salt)) begin errors++; $display("FAIL mid_rst_data: got %h want %h", ack_q[ab].data, exp_line(a2, salt)); end
      if (ack_q[ab].id !== 48'h77) begin errors++; $display("FAIL mid_rst_id: got %h want 77", ack_q[ab].id); end
    end
  endtask

  task automatic test_boundary();
    int ab = ack_q.size(), ob = obs_addr.size(), acc;
    logic [AW-1:0] a = 32'hFFFF_FFF4;
    salt = $urandom;
    bus.fetch_mem_ack_rdy = 1'b1;
    send(a, 48'hABC, acc);
    wait_acks(ab + 1, 40);
    for (int i = 0; i < BEATS && ob + i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[ob+i] !== model_beat_addr(a, i)) begin
        errors++; $display("FAIL edge_addr%0d: got %h want %h", i, obs_addr[ob+i], model_beat_addr(a, i));
      end
    end
    if (ack_q.size() > ab) begin
      checks++;
      if (ack_q[ab].data !== exp_line(a, salt)) begin errors++; $display("FAIL edge_data: got %h want %h", ack_q[ab].data, exp_line(a, salt)); end
    end
  endtask

  task automatic test_random();
    int ab = ack_q.size(), ob = obs_addr.size(), n = 24, acc;
    bit stop = 0;
    logic [AW-1:0] addrs[$];
    logic [IW-1:0] ids[$];
    salt = $urandom;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          logic [AW-1:0] a = $urandom;
          logic [IW-1:0] id = {16'($urandom), 32'($urandom)};
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          addrs.push_back(a);
          ids.push_back(id);
          send(a, id, acc);
        end
        wait_acks(ab + n, 3000);
        stop = 1;
      end
      begin
        for (int g = 0; g < 6000 && !stop; g++) begin
          @(posedge clk); #1;
          bus.fetch_mem_ack_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.fetch_mem_ack_rdy = 1'b1;
    for (int k = 0; k < n && ab + k < ack_q.size(); k++) begin
      checks += 2;
      if (ack_q[ab+k].id !== ids[k]) begin errors++; $display("FAIL rand_id%0d: got %h want %h", k, ack_q[ab+k].id, ids[k]); end
      if (ack_q[ab+k].data !== exp_line(addrs[k], salt)) begin errors++; $display("FAIL rand_data%0d: got %h want %h", k, ack_q[ab+k].data, exp_line(addrs[k], salt)); end
    end
    checks++;
    if (obs_addr.size() != ob + n * BEATS) begin errors++; $display("FAIL rand_reads: got %0d want %0d", obs_addr.size() - ob, n * BEATS); end
    for (int k = 0; k < n * BEATS && ob + k < obs_addr.size(); k++) begin
      checks++;
      if (obs_addr[ob+k] !== model_beat_addr(addrs[k / BEATS], k % BEATS)) begin
        errors++; $display("FAIL rand_addr%0d: got %h want %h", k, obs_addr[ob+k], model_beat_addr(addrs[k / BEATS], k % BEATS));
      end
    end
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL read_during_resp: got %0d cycles want 0", overlap_cnt); end
  endtask

  initial begin
    rst  = 1'b1;
    salt = '0;
    bus.fetch_mem_req_vld      = 1'b0;
    bus.fetch_mem_req_addr     = '0;
    bus.fetch_mem_req_entry_id = '0;
    bus.fetch_mem_ack_rdy      = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/toy_fetch_mem_responder.md
TOY_FETCH_MEM_RESPONDER -- requirements
Module: toy_fetch_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL be the request and memory address width.
REQ-002 Parameter FETCH_DATA_WIDTH, default 256, SHALL be the fetch line width returned per ack.
REQ-003 Parameter BUS_DATA_WIDTH, default 64, SHALL be the backing-memory read width; BEATS = FETCH_DATA_WIDTH/BUS_DATA_WIDTH (default 4, power of two).
REQ-004 Parameter ID_WIDTH, default 48, SHALL be the opaque entry_id width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  SHALL be the sole clock, all state on rising edge.
REQ-007 rst  input  1  SHALL be the synchronous active-high reset.
REQ-008 fetch_mem_req_vld  input  1  SHALL be the request valid.
REQ-009 fetch_mem_req_rdy  output  1  SHALL be the request ready.
REQ-010 fetch_mem_req_addr  input  ADDR_WIDTH  SHALL be the fetch byte address.
REQ-011 fetch_mem_req_entry_id  input  ID_WIDTH  SHALL be the opaque tag echoed on ack.
REQ-012 fetch_mem_ack_vld  output  1  SHALL be the response valid.
REQ-013 fetch_mem_ack_rdy  input  1  SHALL be the response ready.
REQ-014 fetch_mem_ack_data  output  FETCH_DATA_WIDTH  SHALL be the assembled line.
REQ-015 fetch_mem_ack_entry_id  output  ID_WIDTH  SHALL be the echoed tag.
REQ-016 mem_en  output  1  SHALL be the backing-memory read enable.
REQ-017 mem_addr  output  ADDR_WIDTH  SHALL be the backing-memory byte address.
REQ-018 mem_rd_data  input  BUS_DATA_WIDTH  SHALL be read data, valid exactly one cycle after mem_en.

Function
REQ-019 Requests SHALL enter a 2-entry in-order FIFO on vld&&rdy; fetch_mem_req_rdy SHALL equal (FIFO count < 2), independent of same-cycle pops.
REQ-020 FSM states SHALL be IDLE, READ, WAIT, RESP; IDLE->READ when FIFO non-empty; READ->WAIT after issuing beat BEATS-1; WAIT->RESP unconditionally; RESP->READ on ack handshake if FIFO holds another entry after the pop, else RESP->IDLE.
REQ-021 Line base SHALL be req_addr with the low log2(FETCH_DATA_WIDTH/8) bits zeroed; beat k address SHALL be base + k*(BUS_DATA_WIDTH/8), never crossing the line.
REQ-022 In READ, mem_en SHALL be 1 for exactly BEATS consecutive cycles, one beat per cycle; mem_en SHALL be 0 in all other states.
REQ-023 mem_rd_data of beat k SHALL be captured into line bits [k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] in the cycle after its issue.
REQ-024 Request accepted in cycle T with FSM IDLE and FIFO empty SHALL produce fetch_mem_ack_vld first high in cycle T+BEATS+3.
REQ-025 In RESP, fetch_mem_ack_vld SHALL be 1 and ack_data/ack_entry_id SHALL be held stable until fetch_mem_ack_rdy; the FIFO head SHALL pop on that handshake.
REQ-026 Acks SHALL return in request order; entry_id SHALL be the head entry's tag unmodified.
REQ-027 While in RESP with ack_rdy low, no memory reads SHALL be issued; new requests SHALL still be accepted while the FIFO is not full.

Reset
REQ-028 While rst=1: FIFO SHALL be emptied, FSM SHALL enter IDLE, beat counter SHALL be 0.
REQ-029 Reset values: fetch_mem_req_rdy 0, fetch_mem_ack_vld 0, fetch_mem_ack_data 0, fetch_mem_ack_entry_id 0, mem_en 0, mem_addr 0.
REQ-030 Reset asserted mid-READ/WAIT/RESP SHALL discard the in-flight line with no ack; fetch_mem_req_rdy SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro TOY_FETCH_RESP_CRIT_FIRST_EN defined: beat issue order SHALL start at the beat containing req_addr and wrap modulo BEATS; lane placement per REQ-023 unchanged.
REQ-032 Macro TOY_FETCH_RESP_CRIT_FIRST_EN undefined: beats SHALL issue in order 0..BEATS-1; latency per REQ-024 identical in both builds.

Verification
REQ-033 Req addr 0x0000_1008, id 0x5, mem word(a)=a -> mem_addr 0x1000,0x1008,0x1010,0x1018 (macro: 0x1008,0x1010,0x1018,0x1000); ack at T+7, data {0x1018,0x1010,0x1008,0x1000}, id 0x5.
REQ-034 ack_rdy held low 10 cycles in RESP -> ack_vld/data/id stable, mem_en 0 throughout, pop only on release.
REQ-035 Three back-to-back requests ids 1,2,3 with ack_rdy=1 -> rdy low after two accepted, third accepted after first ack, acks ordered 1,2,3.
REQ-036 rst pulsed during beat 2 of READ -> no ack, all outputs at reset values, next request acked with correct data at T+7.
REQ-037 Req addr 0xFFFF_FFF4 -> beats 0xFFFF_FFE0..0xFFFF_FFF8 (macro: starting 0xFFFF_FFF0), no address wrap past line.
